shared_mem_arb: RTL

SHARED_MEM_ARB -- requirements
Module: shared_mem_arb

---
 rtl/shared_mem_arb_if.sv | 26 ++
 rtl/shared_mem_arb.sv | 130 +++++++++++++
 2 files changed

// File: rtl/shared_mem_arb_if.sv
// Core-side bus for shared_mem_arb: packed per-port request fields plus the
// broadcast response (rdata/val_data/grant_id/busy).
interface shared_mem_arb_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 12,
    parameter int DW     = 8
);
    logic [NPORTS-1:0]    mem_req;
    logic [NPORTS-1:0]    mem_we;
    logic [NPORTS*AW-1:0] addr;
    logic [NPORTS*DW-1:0] wdata;
    logic [DW-1:0]        rdata;
    logic [NPORTS-1:0]    val_data;
    logic [1:0]           grant_id;
    logic                 busy;

    modport master (
        output mem_req, mem_we, addr, wdata,
        input  rdata, val_data, grant_id, busy
    );

    modport slave (
        input  mem_req, mem_we, addr, wdata,
        output rdata, val_data, grant_id, busy
    );
endinterface

// File: rtl/shared_mem_arb.sv
// Four-port arbiter in front of a single-ported 2^AW x DW memory, one transaction per 3 cycles.
// Define SMEM_RR_EN for round-robin arbitration; otherwise fixed priority (port 0 highest).
module shared_mem_arb #(
    parameter int NPORTS = 4,
    parameter int AW     = 12,
    parameter int DW     = 8
) (
    input logic            clk,
    input logic            reset,
    shared_mem_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [DW-1:0]       mem_r [0:(1<<AW)-1];
    logic [1:0]          grant_id_r;
    logic                we_r;
    logic [AW-1:0]       addr_r;
    logic [DW-1:0]       wdata_r;
    logic [DW-1:0]       rdata_r;
    logic [NPORTS-1:0]   val_data_r;
    logic                busy_r;
    logic                any_req_s;
    logic [1:0]          pick_s;
    logic [1:0]          cand_s;
`ifdef SMEM_RR_EN
    logic [1:0]          rr_ptr_r;
`endif

    function automatic logic [NPORTS-1:0] one_hot(input logic [1:0] idx);
        logic [NPORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Arbitration: the last candidate assigned wins, so scan from lowest to highest priority
    always_comb begin
        any_req_s = |bus.mem_req;
        pick_s    = 2'd0;
        cand_s    = 2'd0;
`ifdef SMEM_RR_EN
        for (int k = NPORTS; k >= 1; k--) begin
            cand_s = rr_ptr_r + 2'(k);
            if (bus.mem_req[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
`else
        for (int k = NPORTS - 1; k >= 0; k--) begin
            cand_s = 2'(k);
            if (bus.mem_req[cand_s]) begin
                pick_s = cand_s;
            end else begin
                pick_s = pick_s;
            end
        end
`endif
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:  next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, latched transaction and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            grant_id_r <= 2'd0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
            val_data_r <= '0;
            busy_r     <= 1'b0;
`ifdef SMEM_RR_EN
            rr_ptr_r   <= 2'd3;
`endif
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != IDLE);
            // val_data lines up with the RESP cycle so the core can drop mem_req before the next IDLE sample
            val_data_r <= (next_state_s == RESP) ? one_hot(grant_id_r) : '0;
            if (state_r == IDLE && any_req_s) begin
                grant_id_r <= pick_s;
                we_r       <= bus.mem_we[pick_s];
                addr_r     <= bus.addr[int'(pick_s)*AW +: AW];
                wdata_r    <= bus.wdata[int'(pick_s)*DW +: DW];
`ifdef SMEM_RR_EN
                rr_ptr_r   <= pick_s;
`endif
            end
            if (state_r == ACCESS && !we_r) begin
                rdata_r <= mem_r[addr_r];
            end
        end
    end

    // Storage write; gated by state so an async reset before the ACCESS edge cancels it
    always_ff @(posedge clk) begin
        if (state_r == ACCESS && we_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign bus.rdata    = rdata_r;
    assign bus.val_data = val_data_r;
    assign bus.grant_id = grant_id_r;
    assign bus.busy     = busy_r;
endmodule
